// File: rtl/access_sequencer_z3_pkg.sv
// Shared bus definitions for the Zorro III access sequencer and bus arbitration:
// sequencer state encoding, bus-master codes and 68030 SIZ codes.
package access_sequencer_z3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_ACK  = 3'd3,
    ST_END  = 3'd4
  } seq_state_t;

  localparam logic [1:0] BM_Z3    = 2'd2;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;

endpackage

// File: rtl/z3_lane_decode.sv
// Maps active-low Zorro III byte-lane strobes to a 68030 SIZ code and low address bits.
module z3_lane_decode
  import access_sequencer_z3_pkg::*;
(
  input  logic [3:0] ds_n,
  output logic [1:0] siz,
  output logic [1:0] a_lo
);

  logic [3:0] lanes;
  assign lanes = ~ds_n;

  always_comb begin
    siz  = SIZ_LONG;
    a_lo = 2'b00;
    case (lanes)
      4'b1100: begin siz = SIZ_WORD; a_lo = 2'b00; end
      4'b0011: begin siz = SIZ_WORD; a_lo = 2'b10; end
      4'b1000: begin siz = SIZ_BYTE; a_lo = 2'b00; end
      4'b0100: begin siz = SIZ_BYTE; a_lo = 2'b01; end
      4'b0010: begin siz = SIZ_BYTE; a_lo = 2'b10; end
      4'b0001: begin siz = SIZ_BYTE; a_lo = 2'b11; end
      default: begin siz = SIZ_LONG; a_lo = 2'b00; end
    endcase
  end

endmodule

// File: rtl/access_sequencer_z3.sv
// Translates a Zorro III bus-master cycle into a local 68030 cycle and returns
// its termination as DTACK.
//
// state | meaning
// IDLE  | no translated cycle, waiting for a Z3 master strobe
// ARM   | strobes latched, waiting for a CPU clock rising edge
// RUN   | local cycle driven, waiting for DSACK/STERM/BERR or timeout
// ACK   | terminated, waiting for a CPU clock rising edge to end it
// END   | DTACK asserted until the master negates FCS
module access_sequencer_z3
  import access_sequencer_z3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk100,
  input  logic       reset_n,
  input  logic       cpuclk_rising,
  input  logic       cpuclk_falling,
  input  logic [1:0] bm_state,
  output logic       access_state_idle,
  input  logic       fcs_n_in,
  input  logic       doe_in,
  input  logic       read_in,
  input  logic [3:0] ds_n_in,
  output logic       dtack_n_out,
  output logic       dtack_n_oe,
  output logic       as_n_out,
  output logic       ds_n_out,
  output logic       rw_out,
  output logic [1:0] siz_out,
  output logic [1:0] a_lo_out,
  output logic       cpu_oe,
  input  logic [1:0] dsack_n_in,
  input  logic       sterm_n_in,
  input  logic       berr_n_in,
  output logic       bus_error
);

  localparam int SW = 11;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 1'b0, 1'b1, 4'hF, 2'b11, 1'b1, 1'b1};

  seq_state_t    state;
  logic [SW-1:0] sync_in, sync_m, sync_s;
  logic          fcs_n_s, doe_s, read_s, sterm_n_s, berr_n_s;
  logic [3:0]    ds_n_s;
  logic [1:0]    dsack_n_s;
  logic          read_lat;
  logic [3:0]    lanes_lat;
  logic [1:0]    dec_siz, dec_alo;
  logic [TW-1:0] tmo_cnt;
  logic          start, timeout_hit;

  // Only the rising CPU edge paces this sequencer.
  logic unused_cpuclk_falling;
  assign unused_cpuclk_falling = cpuclk_falling;

  assign sync_in = {fcs_n_in, doe_in, read_in, ds_n_in, dsack_n_in, sterm_n_in, berr_n_in};
  assign {fcs_n_s, doe_s, read_s, ds_n_s, dsack_n_s, sterm_n_s, berr_n_s} = sync_s;

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_m <= SYNC_RST;
      sync_s <= SYNC_RST;
    end else begin
      sync_m <= sync_in;
      sync_s <= sync_m;
    end
  end

  z3_lane_decode u_lane_decode (
    .ds_n (lanes_lat),
    .siz  (dec_siz),
    .a_lo (dec_alo)
  );

  assign access_state_idle = (state == ST_IDLE);
  assign start       = (bm_state == BM_Z3) && !fcs_n_s && doe_s && (ds_n_s != 4'hF);
  assign timeout_hit = cpuclk_rising && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      dtack_n_out <= 1'b1;
      dtack_n_oe  <= 1'b0;
      as_n_out    <= 1'b1;
      ds_n_out    <= 1'b1;
      rw_out      <= 1'b1;
      siz_out     <= SIZ_LONG;
      a_lo_out    <= 2'b00;
      cpu_oe      <= 1'b0;
      bus_error   <= 1'b0;
      tmo_cnt     <= '0;
      read_lat    <= 1'b1;
      lanes_lat   <= 4'hF;
    end else begin
      bus_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Entering IDLE from END drove DTACK high for one clock; release here.
          dtack_n_out <= 1'b1;
          dtack_n_oe  <= 1'b0;
          cpu_oe      <= 1'b0;
          rw_out      <= 1'b1;
          siz_out     <= SIZ_LONG;
          a_lo_out    <= 2'b00;
          if (start) begin
            read_lat  <= read_s;
            lanes_lat <= ds_n_s;
            state     <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (fcs_n_s) begin
            state <= ST_IDLE;
          end else if (cpuclk_rising) begin
            cpu_oe   <= 1'b1;
            as_n_out <= 1'b0;
            ds_n_out <= 1'b0;
            rw_out   <= read_lat;
            siz_out  <= dec_siz;
            a_lo_out <= dec_alo;
            tmo_cnt  <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Error wins over a coincident normal termination.
          if (!berr_n_s || timeout_hit) begin
            bus_error <= 1'b1;
            state     <= ST_ACK;
          end else if ((dsack_n_s != 2'b11) || !sterm_n_s) begin
            state <= ST_ACK;
          end else if (cpuclk_rising) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (cpuclk_rising) begin
            as_n_out    <= 1'b1;
            ds_n_out    <= 1'b1;
            dtack_n_out <= 1'b0;
            dtack_n_oe  <= 1'b1;
            state       <= ST_END;
          end
        end
        ST_END: begin
          if (fcs_n_s) begin
            dtack_n_out <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_sequencer_z3.sv
// Directed bench for access_sequencer_z3: lane mapping, termination modes,
// timeout, bus-master change, ARM abort and asynchronous reset.
module tb_access_sequencer_z3;
  import access_sequencer_z3_pkg::*;

  localparam int TMO = 8;

  logic       clk100 = 1'b0;
  logic       reset_n = 1'b1;
  logic       cpuclk_rising, cpuclk_falling;
  logic [1:0] bm_state;
  logic       access_state_idle;
  logic       fcs_n_in, doe_in, read_in;
  logic [3:0] ds_n_in;
  logic       dtack_n_out, dtack_n_oe, as_n_out, ds_n_out, rw_out, cpu_oe;
  logic [1:0] siz_out, a_lo_out;
  logic [1:0] dsack_n_in;
  logic       sterm_n_in, berr_n_in, bus_error;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int phase = 0;

  access_sequencer_z3 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk100            (clk100),
    .reset_n           (reset_n),
    .cpuclk_rising     (cpuclk_rising),
    .cpuclk_falling    (cpuclk_falling),
    .bm_state          (bm_state),
    .access_state_idle (access_state_idle),
    .fcs_n_in          (fcs_n_in),
    .doe_in            (doe_in),
    .read_in           (read_in),
    .ds_n_in           (ds_n_in),
    .dtack_n_out       (dtack_n_out),
    .dtack_n_oe        (dtack_n_oe),
    .as_n_out          (as_n_out),
    .ds_n_out          (ds_n_out),
    .rw_out            (rw_out),
    .siz_out           (siz_out),
    .a_lo_out          (a_lo_out),
    .cpu_oe            (cpu_oe),
    .dsack_n_in        (dsack_n_in),
    .sterm_n_in        (sterm_n_in),
    .berr_n_in         (berr_n_in),
    .bus_error         (bus_error)
  );

  always #5 clk100 = ~clk100;

  // CPU clock = clk100 / 8, edges as single-cycle pulses.
  initial begin
    cpuclk_rising  = 1'b0;
    cpuclk_falling = 1'b0;
    forever begin
      @(negedge clk100);
      phase = (phase + 1) % 8;
      cpuclk_rising  = (phase == 0);
      cpuclk_falling = (phase == 4);
    end
  end

  always @(posedge clk100) if (cpuclk_rising) rise_cnt <= rise_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk100);
  endtask

  task automatic bus_quiet();
    fcs_n_in = 1'b1; doe_in = 1'b0; read_in = 1'b1; ds_n_in = 4'hF;
    dsack_n_in = 2'b11; sterm_n_in = 1'b1; berr_n_in = 1'b1;
  endtask

  task automatic wait_as();
    for (int i = 0; i < 60 && as_n_out !== 1'b0; i++) tick();
  endtask

  // mode: 0 = dsack after dly CPU rises, 1 = sterm, 2 = berr+sterm together, 3 = none
  task automatic run_cycle(input string tag, input logic rd, input logic [3:0] ds,
                           input logic [1:0] esiz, input logic [1:0] ealo,
                           input int mode, input int dly, input int exp_err, input bit drop_bm);
    int snap, errs, err_rise;
    tick();
    fcs_n_in = 1'b0; doe_in = 1'b1; read_in = rd; ds_n_in = ds;
    wait_as();
    chk({tag, "_as"}, as_n_out, 0);
    chk({tag, "_ds"}, ds_n_out, 0);
    chk({tag, "_cpu_oe"}, cpu_oe, 1);
    chk({tag, "_rw"}, rw_out, rd);
    chk({tag, "_siz"}, siz_out, esiz);
    chk({tag, "_alo"}, a_lo_out, ealo);
    snap = rise_cnt; errs = 0; err_rise = 0;
    if (drop_bm) bm_state = 2'd0;
    case (mode)
      0: begin
        for (int i = 0; i < 200 && (rise_cnt - snap) < dly; i++) tick();
        dsack_n_in = 2'b00;
      end
      1: sterm_n_in = 1'b0;
      2: begin sterm_n_in = 1'b0; berr_n_in = 1'b0; end
      default: ;
    endcase
    for (int i = 0; i < 200 && dtack_n_out !== 1'b0; i++) begin
      tick();
      if (bus_error === 1'b1) begin errs++; err_rise = rise_cnt - snap; end
    end
    chk({tag, "_dtack"}, dtack_n_out, 0);
    chk({tag, "_dtack_oe"}, dtack_n_oe, 1);
    chk({tag, "_as_neg"}, as_n_out, 1);
    if (mode == 3) chk({tag, "_tmo_rises"}, err_rise, TMO);
    tick(5);
    if (bus_error === 1'b1) errs++;
    chk({tag, "_berr_cnt"}, errs, exp_err);
    chk({tag, "_dtack_hold"}, dtack_n_out, 0);
    bus_quiet();
    for (int i = 0; i < 20 && access_state_idle !== 1'b1; i++) tick();
    chk({tag, "_idle"}, access_state_idle, 1);
    chk({tag, "_dtack_hi"}, dtack_n_out, 1);
    chk({tag, "_dtack_hi_oe"}, dtack_n_oe, 1);
    tick();
    chk({tag, "_rel_oe"}, dtack_n_oe, 0);
    chk({tag, "_rel_cpu"}, cpu_oe, 0);
  endtask

  initial begin
    int bad, r0;
    bm_state = BM_Z3;
    bus_quiet();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_idle", access_state_idle, 1);
    chk("rst_dtack", dtack_n_out, 1);
    chk("rst_dtack_oe", dtack_n_oe, 0);
    chk("rst_as", as_n_out, 1);
    chk("rst_ds", ds_n_out, 1);
    chk("rst_rw", rw_out, 1);
    chk("rst_siz", siz_out, 0);
    chk("rst_alo", a_lo_out, 0);
    chk("rst_cpu_oe", cpu_oe, 0);
    chk("rst_berr", bus_error, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);

    run_cycle("long_rd",   1'b1, 4'b0000, 2'b00, 2'b00, 0, 3, 0, 1'b0);
    run_cycle("byte_wr",   1'b0, 4'b1011, 2'b01, 2'b01, 1, 0, 0, 1'b0);
    run_cycle("word_lo",   1'b0, 4'b1100, 2'b10, 2'b10, 0, 1, 0, 1'b0);
    run_cycle("word_hi",   1'b1, 4'b0011, 2'b10, 2'b00, 1, 0, 0, 1'b0);
    run_cycle("byte_ds0",  1'b1, 4'b1110, 2'b01, 2'b11, 0, 2, 0, 1'b0);
    run_cycle("odd_lanes", 1'b0, 4'b1010, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    run_cycle("timeout",   1'b1, 4'b0111, 2'b01, 2'b00, 3, 0, 1, 1'b0);
    run_cycle("berr_sterm",1'b0, 4'b0000, 2'b00, 2'b00, 2, 0, 1, 1'b0);
    run_cycle("bm_drop",   1'b1, 4'b0000, 2'b00, 2'b00, 0, 2, 0, 1'b1);

    // bm_state now 0: a fresh master strobe must be ignored
    fcs_n_in = 1'b0; doe_in = 1'b1; read_in = 1'b1; ds_n_in = 4'h0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (access_state_idle !== 1'b1 || as_n_out !== 1'b0 && cpu_oe !== 1'b0) bad++;
      if (as_n_out !== 1'b1) bad++;
    end
    chk("bm0_ignored", bad, 0);
    bus_quiet();
    bm_state = BM_Z3;
    tick(4);

    // FCS negated while waiting in ARM
    r0 = rise_cnt;
    for (int i = 0; i < 20 && rise_cnt == r0; i++) tick();
    fcs_n_in = 1'b0; doe_in = 1'b1; read_in = 1'b0; ds_n_in = 4'h0;
    for (int i = 0; i < 6 && access_state_idle !== 1'b0; i++) tick();
    chk("arm_enter", access_state_idle, 0);
    fcs_n_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (as_n_out !== 1'b1 || cpu_oe !== 1'b0 || dtack_n_oe !== 1'b0) bad++;
    end
    chk("arm_abort_nodrive", bad, 0);
    chk("arm_abort_idle", access_state_idle, 1);
    bus_quiet();
    tick(4);

    // Reset while in END
    fcs_n_in = 1'b0; doe_in = 1'b1; read_in = 1'b1; ds_n_in = 4'h0;
    wait_as();
    chk("rstend_as", as_n_out, 0);
    dsack_n_in = 2'b00;
    for (int i = 0; i < 60 && dtack_n_out !== 1'b0; i++) tick();
    chk("rstend_dtack", dtack_n_out, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstend_dtack_oe", dtack_n_oe, 0);
    chk("rstend_dtack_n", dtack_n_out, 1);
    chk("rstend_cpu_oe", cpu_oe, 0);
    chk("rstend_as_n", as_n_out, 1);
    chk("rstend_idle", access_state_idle, 1);
    chk("rstend_rw", rw_out, 1);
    bus_quiet();
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("rstend_post_oe", dtack_n_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/access_sequencer_z3.md
ACCESS_SEQUENCER_Z3 -- requirements
Module: access_sequencer_z3

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the CPU-clock cycles allowed for local termination before forced error end.
REQ-002 SHALL have port clk100, input, 1: system clock; the only clock.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports cpuclk_rising / cpuclk_falling, input, 1 each: single-clk100 pulses marking CPU clock edges.
REQ-005 SHALL have port bm_state, input, 2: bus master; 2 = Zorro III master owns the bus.
REQ-006 SHALL have port access_state_idle, output, 1: high when no translated cycle is in progress.
REQ-007 SHALL have ports fcs_n_in, doe_in, read_in (input, 1) and ds_n_in (input, 4; bit 3 = D31:24): Zorro III master cycle strobes.
REQ-008 SHALL have ports dtack_n_out, dtack_n_oe, output, 1: Zorro III cycle termination.
REQ-009 SHALL have ports as_n_out, ds_n_out, rw_out (output, 1), siz_out (output, 2), a_lo_out (output, 2), cpu_oe (output, 1): local 68030 cycle drive.
REQ-010 SHALL have ports dsack_n_in (input, 2), sterm_n_in and berr_n_in (input, 1): local termination.
REQ-011 SHALL have port bus_error, output, 1: one-clk100 pulse on error termination.

Function
REQ-012 SHALL pass fcs_n_in, doe_in, read_in, ds_n_in, dsack_n_in, sterm_n_in and berr_n_in through 2-flop synchronisers; all decisions use synchronised values.
REQ-013 SHALL implement states IDLE, ARM, RUN, ACK, END, in that order.
REQ-014 SHALL set access_state_idle high exactly when the state is IDLE.
REQ-015 IDLE->ARM SHALL occur when bm_state==2, fcs_n low, doe high and at least one ds_n bit low; RW and lanes are latched here.
REQ-016 ARM->RUN SHALL occur on the next cpuclk_rising, asserting cpu_oe=1, as_n_out=0, ds_n_out=0, rw_out=latched read, siz_out/a_lo_out per REQ-017.
REQ-017 Lane map (active lanes -> siz,a_lo): all four->00,00; DS3+DS2->10,00; DS1+DS0->10,10; single DS3/2/1/0->01 with a_lo 00/01/10/11; any other pattern->00,00.
REQ-018 RUN->ACK SHALL occur on any clk100 where either dsack_n bit is low or sterm_n is low.
REQ-019 RUN SHALL also exit to ACK, pulsing bus_error, when berr_n is low or TIMEOUT_CYCLES cpuclk_rising pulses elapse in RUN; the timeout counter clears on RUN entry.
REQ-020 ACK SHALL wait for cpuclk_rising, then negate as_n_out/ds_n_out, drive dtack_n_out=0 with dtack_n_oe=1, and enter END.
REQ-021 END SHALL hold dtack_n_out low until fcs_n is high, then drive dtack_n_out=1 for one clk100, release dtack_n_oe and cpu_oe, and enter IDLE.
REQ-022 bm_state leaving 2 while not in IDLE SHALL NOT abort; the cycle completes, and IDLE accepts no new start.
REQ-023 Simultaneous berr and dsack/sterm in RUN SHALL be treated as error (bus_error pulses).
REQ-024 fcs_n rising during ARM SHALL return to IDLE without driving the local bus.

Reset
REQ-025 Reset assertion SHALL immediately force IDLE, access_state_idle=1, all active-low outputs =1, all *_oe and cpu_oe =0, rw_out=1, siz_out=00, a_lo_out=00, bus_error=0, timeout counter 0, synchronisers to inactive levels.
REQ-026 Reset mid-cycle SHALL release all drives within the same asynchronous event, with no DTACK pulse.

Structure
REQ-027 State encodings, bm_state value 2 (BM_Z3) and SIZ codes SHALL live in a shared bus package, also used by bus arbitration.
REQ-028 Lane-to-SIZ/A mapping SHALL be a sub-module z3_lane_decode; the rest stays in one module.

Verification
REQ-029 Long read: bm_state=2, fcs/doe, ds_n=0000, read=1, dsack_n=00 after 3 CPU clocks -> siz=00, a_lo=00, rw=1, dtack low until fcs negated, idle returns.
REQ-030 Byte write: ds_n=1011 (DS2), read=0 -> siz=01, a_lo=01, rw=0.
REQ-031 Timeout: TIMEOUT_CYCLES=8, no dsack/sterm -> bus_error pulse after 8 cpuclk_rising in RUN, dtack still asserted.
REQ-032 Berr+sterm same clk100 -> single bus_error pulse, normal DTACK end.
REQ-033 bm_state 2->0 during RUN -> cycle completes; a new fcs with bm_state=0 is ignored, access_state_idle stays 1.
REQ-034 reset_n low while in END -> outputs at reset values without waiting for a clock edge, dtack_n_oe=0.
